// File: rtl/ep_tx_arbiter_pkg.sv
// Shared definitions for the endpoint TX arbiter: state encoding,
// requester limits, requester index assignments and modular index helper.
package ep_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BUSY  = 2'd2
   } arb_state_t;

   localparam int MAX_REQ = 8;
   localparam int IDX_W   = 3;

   // Requester slots as wired at the endpoint top level.
   localparam int INT_REQ   = 0;
   localparam int RXDMA_REQ = 1;
   localparam int TXDMA_REQ = 2;

   // (a + b) mod n for indices already below n; n is the requester count, not 8.
   function automatic logic [IDX_W-1:0] mod_add(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b,
                                                 input int n);
      logic [IDX_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 4'(n))
         s = s - 4'(n);
      return s[IDX_W-1:0];
   endfunction

endpackage

// File: rtl/ep_tx_arbiter_rr_pick.sv
// Round-robin selector: rotate requests so the pointer slot is bit 0,
// take the lowest set bit, then rotate the result back to a requester index.
module rr_pick
   import ep_tx_arbiter_pkg::*;
#(
   parameter int N_REQ = 3
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] p,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   logic [MAX_REQ-1:0] req_pad;
   logic [N_REQ-1:0]   rot;
   logic [IDX_W-1:0]   off;

   // Padding to the full index range keeps every index expression exact-width.
   assign req_pad = MAX_REQ'(req);

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot[gi] = req_pad[mod_add(p, IDX_W'(gi), N_REQ)];
   end

   assign valid = |rot;

   // Lowest set bit of the rotated vector is the first requester at or after p.
   always_comb begin
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i])
            off = IDX_W'(i);
      end
      idx = mod_add(p, off, N_REQ);
   end

endmodule

// File: rtl/ep_tx_arbiter.sv
// Round-robin owner arbitration for the endpoint transmit path: grant one
// requester, track it until it releases, revoke stale grants, flag intruders.
module ep_tx_arbiter
   import ep_tx_arbiter_pkg::*;
#(
   parameter int N_REQ         = 3,
   parameter int GRANT_TIMEOUT = 1024
) (
   input  logic             trn_clk,
   input  logic             reset,
   input  logic             trn_lnk_up_n,
   input  logic [N_REQ-1:0] req_ep,
   input  logic [N_REQ-1:0] driving_interface,
   output logic [N_REQ-1:0] my_turn,
   output logic             ep_busy,
   output logic             grant_timeout_err,
   output logic             protocol_err
);

   localparam int              CNT_W    = $clog2(GRANT_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);

   arb_state_t        state_reg, state_next;
   logic [IDX_W-1:0]  w_reg, w_next;
   logic [IDX_W-1:0]  p_reg, p_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [N_REQ-1:0]  my_turn_reg, my_turn_next;
   logic              busy_reg, busy_next;
   logic              terr_reg, terr_next;
   logic              perr_reg, perr_next;

   logic [MAX_REQ-1:0] drv_pad;
   logic [MAX_REQ-1:0] own_mask;
   logic [MAX_REQ-1:0] grant_oh;
   logic               drv_owner;
   logic               stray;
   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req   (req_ep),
      .p     (p_reg),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign drv_pad   = MAX_REQ'(driving_interface);
   assign drv_owner = drv_pad[w_reg];
   assign grant_oh  = MAX_REQ'(1) << pick_idx;
   // Only the current winner may drive, and only once the path is allocated.
   assign own_mask  = (state_reg == IDLE) ? '0 : (MAX_REQ'(1) << w_reg);
   assign stray     = |(drv_pad & ~own_mask);

   // Next-state and output decode; driving_interface beats timeout/link-down in GRANT.
   always_comb begin
      state_next   = state_reg;
      w_next       = w_reg;
      p_next       = p_reg;
      cnt_next     = cnt_reg;
      my_turn_next = my_turn_reg;
      terr_next    = terr_reg;
      perr_next    = perr_reg | stray;
      case (state_reg)
         IDLE: begin
            if (!trn_lnk_up_n && pick_valid) begin
               w_next       = pick_idx;
               my_turn_next = grant_oh[N_REQ-1:0];
               cnt_next     = '0;
               state_next   = GRANT;
            end
         end
         GRANT: begin
            if (drv_owner) begin
               my_turn_next = '0;
               state_next   = BUSY;
            end else if (trn_lnk_up_n || (cnt_reg == CNT_LAST)) begin
               my_turn_next = '0;
               p_next       = mod_add(w_reg, IDX_W'(1), N_REQ);
               state_next   = IDLE;
               if (cnt_reg == CNT_LAST)
                  terr_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         BUSY: begin
            // Link-down is ignored here; the owner always finishes its own release.
            if (!drv_owner) begin
               p_next     = mod_add(w_reg, IDX_W'(1), N_REQ);
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      busy_next = (state_next != IDLE);
   end

   // State and registered outputs; reset forgets any owner, even mid-transfer.
   always_ff @(posedge trn_clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         w_reg       <= '0;
         p_reg       <= '0;
         cnt_reg     <= '0;
         my_turn_reg <= '0;
         busy_reg    <= 1'b0;
         terr_reg    <= 1'b0;
         perr_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         w_reg       <= w_next;
         p_reg       <= p_next;
         cnt_reg     <= cnt_next;
         my_turn_reg <= my_turn_next;
         busy_reg    <= busy_next;
         terr_reg    <= terr_next;
         perr_reg    <= perr_next;
      end
   end

   assign my_turn           = my_turn_reg;
   assign ep_busy           = busy_reg;
   assign grant_timeout_err = terr_reg;
   assign protocol_err      = perr_reg;

endmodule
